product_bcd_convert: RTL and testbench

//  Downstream stage of the 4-bit sequential multiplier. It takes the multiplier's
//  8-bit product plus its sign mode and produces a sign flag and three BCD digits
//  (hundreds/tens/ones) for the 7-segment display path.

---
 rtl/product_bcd_convert.sv | 116 +++++++++++
 tb/tb_product_bcd_convert.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_convert.sv
// Sequential binary-to-BCD converter for the multiplier display path.
// It accepts the multiplier product and its sign mode. It returns a sign flag
// and DIGITS BCD digits, produced by double-dabble at one shift per clock.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last completed result
// SHIFT | adjust-and-shift in progress, WIDTH cycles, busy=1
// DONE  | result just written, done=1 for this single cycle
module product_bcd_convert #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      product,
  input  logic                  sign,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  negative,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int BW    = DIGITS * 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [BW-1:0]      bcd_work;
  logic [WIDTH-1:0]   mag;
  logic [CNT_W-1:0]   cnt;
  logic               neg_l;

  logic [BW-1:0]      bcd_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic               is_neg;
  logic [WIDTH-1:0]   mag_in;

  // Sign decode and magnitude of the incoming product; the negation wraps
  // modulo 2**WIDTH, so the most negative value maps to its unsigned magnitude.
  always_comb begin
    is_neg = sign & product[WIDTH-1];
    mag_in = is_neg ? ((~product) + WIDTH'(1)) : product;
  end

  // Add 3 to every digit >= 5, then shift the combined register left by one.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_work[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_work[i*4 +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, mag} << 1;
  end

  // Control FSM with registered outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bcd_work <= '0;
      mag      <= '0;
      cnt      <= '0;
      neg_l    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      negative <= 1'b0;
      bcd      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mag      <= mag_in;
            neg_l    <= is_neg;
            bcd_work <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            valid    <= 1'b0;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          bcd_work <= shifted[BW+WIDTH-1:WIDTH];
          mag      <= shifted[WIDTH-1:0];
          cnt      <= cnt + CNT_W'(1);
          // The last shift lands directly in the output register.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bcd      <= shifted[BW+WIDTH-1:WIDTH];
            negative <= neg_l;
            valid    <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_convert.sv
// Directed bench for product_bcd_convert; expected values hand-computed.
module tb_product_bcd_convert;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  product;
  logic        sign;
  logic        busy;
  logic        done;
  logic        valid;
  logic        negative;
  logic [11:0] bcd;

  int checks = 0;
  int errors = 0;
  logic [11:0] last_bcd = '0;
  logic        last_neg = 1'b0;

  product_bcd_convert #(.WIDTH(8), .DIGITS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .product  (product),
    .sign     (sign),
    .busy     (busy),
    .done     (done),
    .valid    (valid),
    .negative (negative),
    .bcd      (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion at the next edge and wait (bounded) for done.
  task automatic run(input string tag, input logic [7:0] p, input logic s,
                     input logic [11:0] exp_bcd, input logic exp_neg);
    int lat;
    int bc;
    start   = 1'b1;
    product = p;
    sign    = s;
    step();
    start   = 1'b0;
    product = 8'($urandom);
    sign    = 1'($urandom);
    check({tag, "_accept_busy"}, 32'(busy), 32'd1);
    check({tag, "_valid_clr"}, 32'(valid), 32'd0);
    check({tag, "_hold_bcd"}, 32'(bcd), 32'(last_bcd));
    check({tag, "_hold_neg"}, 32'(negative), 32'(last_neg));
    lat = 0;
    bc  = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
    check({tag, "_done_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, "_neg"}, 32'(negative), 32'(exp_neg));
    check({tag, "_valid"}, 32'(valid), 32'd1);
    last_bcd = exp_bcd;
    last_neg = exp_neg;
  endtask

  initial begin
    int lat;
    int dcount;
    rst_n   = 1'b0;
    start   = 1'b0;
    product = '0;
    sign    = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_neg", 32'(negative), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: unsigned full scale
    run("u_ff", 8'hFF, 1'b0, 12'h255, 1'b0);
    step();
    check("u_ff_done_pulse", 32'(done), 32'd0);
    check("u_ff_valid_idle", 32'(valid), 32'd1);
    check("u_ff_bcd_idle", 32'(bcd), 32'h255);

    // 2: signed most negative
    run("s_80", 8'h80, 1'b1, 12'h128, 1'b1);
    step();

    // 3: signed small negative, then the same bits unsigned
    run("s_f1", 8'hF1, 1'b1, 12'h015, 1'b1);
    step();
    run("u_f1", 8'hF1, 1'b0, 12'h241, 1'b0);
    step();

    // 4: signed zero
    run("s_00", 8'h00, 1'b1, 12'h000, 1'b0);
    step();

    // 5: start while busy is ignored
    start   = 1'b1;
    product = 8'h63;
    sign    = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    start   = 1'b1;
    product = 8'hFF;
    step();
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    check("busy_ign_latency", 32'(lat), 32'd8);
    check("busy_ign_bcd", 32'(bcd), 32'h099);
    check("busy_ign_neg", 32'(negative), 32'd0);
    last_bcd = 12'h099;
    last_neg = 1'b0;
    // back-to-back start accepted on the done cycle
    run("b2b_2a", 8'h2A, 1'b0, 12'h042, 1'b0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) dcount++;
    end
    check("no_extra_done", 32'(dcount), 32'd0);

    // 6: reset in the middle of a conversion
    start   = 1'b1;
    product = 8'hFF;
    sign    = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_neg", 32'(negative), 32'd0);
    step();
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) dcount++;
    end
    check("midrst_no_done", 32'(dcount), 32'd0);
    last_bcd = 12'h000;
    last_neg = 1'b0;
    run("post_rst_0c", 8'h0C, 1'b0, 12'h012, 1'b0);
    step();
    run("post_rst_s9c", 8'h9C, 1'b1, 12'h100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
